// File: rtl/seg_pkg.sv
// Shared phase encodings and display constants for the seven-segment scheduler slice.
// No logic, so no latency; no flow control involved.
// Imported by the scheduler, its interface users and the testbench.
package seg_pkg;

    typedef enum logic [1:0] {
        PH_SRC0 = 2'd0,
        PH_SRC1 = 2'd1,
        PH_SRC2 = 2'd2
    } phase_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // A dwell of zero would never expire, so it is treated as a single tick.
    function automatic int dwell_eff(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic phase_t phase_after(input phase_t p);
        case (p)
            PH_SRC0: return PH_SRC1;
            PH_SRC1: return PH_SRC2;
            default: return PH_SRC0;
        endcase
    endfunction

endpackage

// File: rtl/seg_phase_scheduler_if.sv
// Control, source and display-pin bundle between animation generators and the scheduler.
// Pure wiring, zero latency; no backpressure, display pins are always accepted.
// master = source/control side, slave = scheduler.
interface seg_phase_scheduler_if;

    logic [3:0] blank;
    logic       pause;
    logic       next;
    logic [3:0] src0_an;
    logic [6:0] src0_seg;
    logic [3:0] src1_an;
    logic [6:0] src1_seg;
    logic [3:0] src2_an;
    logic [6:0] src2_seg;
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] phase;
    logic       tick;

    modport master (
        output blank, pause, next,
        output src0_an, src0_seg, src1_an, src1_seg, src2_an, src2_seg,
        input  an, seg, phase, tick
    );

    modport slave (
        input  blank, pause, next,
        input  src0_an, src0_seg, src1_an, src1_seg, src2_an, src2_seg,
        output an, seg, phase, tick
    );

endinterface

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: wrap is high on the last count, tick is wrap registered.
// tick lags wrap by one cycle; no backpressure, it never stalls.
// Reusable by the animation sources for their own frame rates.
module seg_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clock,
    input  logic start,
    output logic wrap,
    output logic tick
);

    localparam int DIV = (TICK_DIV < 1) ? 1 : TICK_DIV;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign wrap = (cnt == LAST);

    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            cnt  <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg_phase_scheduler.sv
// Time-shares one 4-digit display between three sources in programmable dwell phases.
// an/seg follow the pre-edge phase with one cycle latency; no backpressure, pins always accept.
// pause freezes dwell counting only; next skips a phase immediately unless phase 2 is terminal.
module seg_phase_scheduler
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int DWELL0   = 8,
    parameter int DWELL1   = 4,
    parameter int DWELL2   = 8,
    parameter int LOOP     = 0
) (
    input  logic                  clock,
    input  logic                  start,
    seg_phase_scheduler_if.slave  bus
);

    localparam int D0   = dwell_eff(DWELL0);
    localparam int D1   = dwell_eff(DWELL1);
    localparam int D2   = dwell_eff(DWELL2);
    localparam int D01  = (D0 > D1) ? D0 : D1;
    localparam int DMAX = (D01 > D2) ? D01 : D2;
    localparam int DW   = $clog2(DMAX) + 1;

    logic          wrap;
    logic          tick;
    phase_t        ph;
    logic [DW-1:0] dwell;
    logic [DW-1:0] last;
    logic [3:0]    sel_an;
    logic [6:0]    sel_seg;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          terminal;
    logic          count_en;
    logic          expired;
    logic          adv;

    seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .start (start),
        .wrap  (wrap),
        .tick  (tick)
    );

    always_comb begin
        last    = DW'(D0 - 1);
        sel_an  = bus.src0_an;
        sel_seg = bus.src0_seg;
        case (ph)
            PH_SRC0: begin
                last    = DW'(D0 - 1);
                sel_an  = bus.src0_an;
                sel_seg = bus.src0_seg;
            end
            PH_SRC1: begin
                last    = DW'(D1 - 1);
                sel_an  = bus.src1_an;
                sel_seg = bus.src1_seg;
            end
            PH_SRC2: begin
                last    = DW'(D2 - 1);
                sel_an  = bus.src2_an;
                sel_seg = bus.src2_seg;
            end
            default: begin
                sel_an  = AN_OFF;
                sel_seg = SEG_BLANK;
            end
        endcase
    end

    // Dwell counts on the prescaler's terminal count so the phase moves on the same
    // edge that raises tick, keeping phase changes on whole tick boundaries.
    assign terminal = (ph == PH_SRC2) && (LOOP == 0);
    assign count_en = wrap && !bus.pause && !terminal;
    assign expired  = count_en && (dwell == last);
    assign adv      = !terminal && (bus.next || expired);

    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            ph    <= PH_SRC0;
            dwell <= '0;
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= sel_an | bus.blank;
            seg_q <= sel_seg;
            if (adv) begin
                ph    <= phase_after(ph);
                dwell <= '0;
            end else if (count_en) begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
    assign bus.phase = ph;
    assign bus.tick  = tick;

endmodule

// File: tb/tb_seg_phase_scheduler.sv
// Directed bench for seg_phase_scheduler with TICK_DIV=4, dwells 3/2/2; a LOOP=1 twin shares stimulus.
module tb_seg_phase_scheduler;
    import seg_pkg::*;

    logic clock = 1'b0;
    logic start = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   moved = 0;
    int   ticks = 0;

    seg_phase_scheduler_if bus();
    seg_phase_scheduler_if bus_l();

    seg_phase_scheduler #(
        .TICK_DIV(4), .DWELL0(3), .DWELL1(2), .DWELL2(2), .LOOP(0)
    ) u_dut (
        .clock (clock),
        .start (start),
        .bus   (bus)
    );

    seg_phase_scheduler #(
        .TICK_DIV(4), .DWELL0(3), .DWELL1(2), .DWELL2(2), .LOOP(1)
    ) u_loop (
        .clock (clock),
        .start (start),
        .bus   (bus_l)
    );

    assign bus_l.blank    = bus.blank;
    assign bus_l.pause    = bus.pause;
    assign bus_l.next     = bus.next;
    assign bus_l.src0_an  = bus.src0_an;
    assign bus_l.src0_seg = bus.src0_seg;
    assign bus_l.src1_an  = bus.src1_an;
    assign bus_l.src1_seg = bus.src1_seg;
    assign bus_l.src2_an  = bus.src2_an;
    assign bus_l.src2_seg = bus.src2_seg;

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called just after an edge; the release lands with the prescaler at 0.
    task automatic reset_dut();
        start = 1'b1;
        step(2);
        start = 1'b0;
    endtask

    initial begin
        bus.blank    = 4'h0;
        bus.pause    = 1'b0;
        bus.next     = 1'b0;
        bus.src0_an  = 4'h0;
        bus.src0_seg = 7'h00;
        bus.src1_an  = 4'h0;
        bus.src1_seg = 7'h00;
        bus.src2_an  = 4'h0;
        bus.src2_seg = 7'h00;

        // Asynchronous reset before any clock edge.
        #1 start = 1'b1;
        #1;
        chk("rst_an",    32'(bus.an),    32'hF);
        chk("rst_seg",   32'(bus.seg),   32'h7F);
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_tick",  32'(bus.tick),  32'd0);

        bus.src0_an  = 4'b1010;
        bus.src0_seg = 7'h12;
        bus.src1_an  = 4'b0110;
        bus.src1_seg = 7'h34;
        bus.src2_an  = 4'b0101;
        bus.src2_seg = 7'h56;
        step(1);
        chk("rst_hold_an", 32'(bus.an), 32'hF);
        start = 1'b0;

        // Natural sequencing: 12 clocks in phase 0, 8 in phase 1.
        step(1);
        chk("first_an",  32'(bus.an),  32'b1010);
        chk("first_seg", 32'(bus.seg), 32'h12);
        step(10);
        chk("ph0_edge11", 32'(bus.phase), 32'd0);
        step(1);
        chk("ph1_edge12", 32'(bus.phase), 32'd1);
        chk("an_lag",     32'(bus.an),    32'b1010);
        chk("tick_edge12", 32'(bus.tick), 32'd1);
        step(1);
        chk("an_src1",    32'(bus.an),    32'b0110);
        chk("seg_src1",   32'(bus.seg),   32'h34);
        chk("tick_low",   32'(bus.tick),  32'd0);
        step(6);
        chk("ph1_edge19", 32'(bus.phase), 32'd1);
        step(1);
        chk("ph2_edge20", 32'(bus.phase), 32'd2);
        chk("loop_ph2",   32'(bus_l.phase), 32'd2);
        step(1);
        chk("an_src2",    32'(bus.an),    32'b0101);
        step(6);
        chk("loop_edge27", 32'(bus_l.phase), 32'd2);
        step(1);
        chk("loop_wrap",  32'(bus_l.phase), 32'd0);
        chk("term_hold",  32'(bus.phase),   32'd2);

        // Terminal phase ignores dwell expiry and next.
        moved = 0;
        for (int i = 0; i < 200; i++) begin
            bus.next = (i % 10 == 0);
            step(1);
            if (bus.phase != 2'd2) moved++;
        end
        bus.next = 1'b0;
        chk("term_200", 32'(moved), 32'd0);

        // Blanking in phase 1.
        reset_dut();
        step(13);
        chk("blk_ph1", 32'(bus.phase), 32'd1);
        bus.blank = 4'b0001;
        step(1);
        chk("blk_one", 32'(bus.an), 32'b0111);
        bus.blank = 4'hF;
        step(1);
        chk("blk_all_an",  32'(bus.an),  32'hF);
        chk("blk_all_seg", 32'(bus.seg), 32'h34);
        bus.blank = 4'h0;

        // Mid-operation asynchronous reset, then a full phase 0 dwell again.
        chk("mid_pre", 32'(bus.phase), 32'd1);
        start = 1'b1;
        #2;
        chk("mid_an",    32'(bus.an),    32'hF);
        chk("mid_seg",   32'(bus.seg),   32'h7F);
        chk("mid_phase", 32'(bus.phase), 32'd0);
        step(1);
        start = 1'b0;
        step(11);
        chk("mid_ph0_11", 32'(bus.phase), 32'd0);
        step(1);
        chk("mid_ph1_12", 32'(bus.phase), 32'd1);

        // Skip after one tick in phase 0; phase 1 then takes exactly two ticks.
        reset_dut();
        step(4);
        bus.next = 1'b1;
        step(1);
        bus.next = 1'b0;
        chk("skip_ph1", 32'(bus.phase), 32'd1);
        step(6);
        chk("skip_ph1_hold", 32'(bus.phase), 32'd1);
        step(1);
        chk("skip_ph2", 32'(bus.phase), 32'd2);

        // next on the expiry edge moves only one phase.
        reset_dut();
        step(11);
        bus.next = 1'b1;
        step(1);
        bus.next = 1'b0;
        chk("coinc_ph1", 32'(bus.phase), 32'd1);
        step(7);
        chk("coinc_hold", 32'(bus.phase), 32'd1);
        step(1);
        chk("coinc_ph2", 32'(bus.phase), 32'd2);

        // Pause mid phase 1 after one counted tick; prescaler keeps running.
        reset_dut();
        step(16);
        chk("pause_pre", 32'(bus.phase), 32'd1);
        bus.pause = 1'b1;
        moved = 0;
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (bus.phase != 2'd1) moved++;
            if (bus.tick) ticks++;
        end
        bus.pause = 1'b0;
        chk("pause_hold",  32'(moved), 32'd0);
        chk("pause_ticks", 32'(ticks), 32'd10);
        step(3);
        chk("unpause_ph1", 32'(bus.phase), 32'd1);
        step(1);
        chk("unpause_ph2", 32'(bus.phase), 32'd2);

        // next still advances while paused.
        reset_dut();
        step(2);
        bus.pause = 1'b1;
        bus.next  = 1'b1;
        step(1);
        bus.next  = 1'b0;
        bus.pause = 1'b0;
        chk("pause_next", 32'(bus.phase), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_phase_scheduler.md
Name: seg_phase_scheduler

Overview:
- Sequences three seven-segment animation sources onto one shared 4-digit display (anodes `an`, segments `seg`).
- Time-shares the display in fixed phases: source 0, then source 1, then source 2, each held for a programmable number of slow ticks.
- Supports manual skip, pause and per-digit blanking.
- Sits between the animation generators and the board display pins; replaces ad-hoc index/count muxing.

Parameters:
- TICK_DIV, 25000000, clock cycles per dwell tick (min 1).
- DWELL0, 8, ticks spent in phase 0 (0 treated as 1).
- DWELL1, 4, ticks spent in phase 1 (0 treated as 1).
- DWELL2, 8, ticks spent in phase 2 before wrapping (used only when LOOP=1; 0 treated as 1).
- LOOP, 0, 1 = phase 2 wraps to phase 0; 0 = phase 2 is terminal.

Ports:
- clock  in  1  system clock; all state on rising edge.
- start  in  1  asynchronous active-high reset.
- blank  in  4  per-digit force-off; bit i=1 forces an[i]=1.
- pause  in  1  level; freezes the dwell counter.
- next  in  1  single-cycle synchronous pulse; skips to the following phase.
- src0_an  in  4  source 0 anodes, active low.
- src0_seg  in  7  source 0 segments, active low.
- src1_an / src1_seg  in  4 / 7  source 1.
- src2_an / src2_seg  in  4 / 7  source 2.
- an  out  4  display anodes, active low, registered.
- seg  out  7  display segments, active low, registered.
- phase  out  2  current phase (0, 1, 2); value 3 never produced.
- tick  out  1  one-cycle prescaler pulse.

Behaviour:
- Reset (start=1, asynchronous): an=4'b1111, seg=7'b1111111, phase=0, tick=0, prescaler=0, dwell count=0. Outputs go blank without waiting for a clock edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly the cycle after the count reaches TICK_DIV-1 (registered).
  - Free-running; unaffected by pause and next.
- Dwell counter:
  - Increments on a tick when pause=0 and the phase is not terminal.
  - On the tick where the count equals DWELLn-1, the phase advances and the count clears to 0.
- Phase FSM:
  - PH0 → PH1 → PH2.
  - PH2 → PH0 only if LOOP=1; with LOOP=0, PH2 is absorbing, and both the dwell counter and next are ignored.
- next:
  - Advances the phase on the same edge and clears the dwell count; the prescaler is not cleared.
  - next while pause=1 still advances.
  - next coincident with dwell expiry advances exactly one phase.
- Output path, one-cycle latency: an <= sel_an | blank; seg <= sel_seg, where sel is the source of the phase value *before* the edge.
  - On a phase change, the new source appears on an/seg one cycle after phase updates.
- Widths: dwell counter is $clog2(max DWELL)+1 bits; no overflow possible because it clears at expiry.

Decomposition:
- Shared package `seg_pkg`:
  - Phase encodings PH_SRC0=2'd0, PH_SRC1=2'd1, PH_SRC2=2'd2.
  - Constants SEG_BLANK=7'h7F and AN_OFF=4'hF.
- One sub-module, `seg_tick_gen`: parameterised prescaler producing `tick`. Reusable by the animation sources.

Test Plan (TICK_DIV=4, DWELL0=3, DWELL1=2, DWELL2=2, LOOP=0 unless stated):
- Reset: start=1, all sources driving 4'b0000/7'h00 → an=4'hF, seg=7'h7F, phase=0 with no clock edge. Release, then one edge → an=src0_an, seg=src0_seg.
- Natural sequencing:
  - phase=1 at 12 clocks after reset release; phase=2 at 8 clocks later.
  - Held at 2 for 200 cycles with next pulsed → never changes.
  - With LOOP=1 → phase=0 at 8 clocks after entering 2.
- Blanking: phase 1, src1_an=4'b0110, blank=4'b0001 → an=4'b0111 next cycle; blank=4'hF → an=4'hF, seg still=src1_seg.
- Skip:
  - next in phase 0 after 1 tick → phase=1 next edge; phase=2 exactly 2 ticks later.
  - next on the same cycle as phase 0 expiry → phase=1, not 2.
- Pause: pause=1 for 40 cycles mid phase 1 (1 tick counted) → phase stays 1, tick keeps pulsing. Release → phase=2 after 1 further tick.
- Mid-operation reset: assert start during phase 1 between edges → an=4'hF, seg=7'h7F, phase=0 immediately. Release → full PH0 dwell (12 clocks) again.
